enet_mii_tx: RTL and testbench

ENET_MII_TX -- requirements
Module: enet_mii_tx

---
 rtl/enet_pkg.sv | 31 +++
 rtl/enet_crc32_nibble.sv | 25 ++
 rtl/enet_mii_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_enet_mii_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enet_pkg.sv
// Shared definitions for the MII transmit path: FSM states, preamble
// nibbles, CRC-32 constants and the minimum frame length before FCS.
package enet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_PAD      = 3'd3,
    ST_FCS      = 3'd4,
    ST_IFG      = 3'd5,
    ST_DISCARD  = 3'd6
  } tx_state_e;

  localparam logic [3:0]  NIB_PREAMBLE = 4'h5;
  localparam logic [3:0]  NIB_SFD      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
  localparam logic [5:0]  MIN_FRAME    = 6'd60;

  // Byte counter increment that sticks at the minimum frame length.
  function automatic logic [5:0] byte_cnt_inc(input logic [5:0] cnt);
    if (cnt >= MIN_FRAME) begin
      return MIN_FRAME;
    end else begin
      return cnt + 6'd1;
    end
  endfunction

endpackage

// File: rtl/enet_crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble (LSB first).
module enet_crc32_nibble
  import enet_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_v;

  // Fold the nibble into the low bits, then shift out four bits.
  always_comb begin
    crc_v = crc_i ^ {28'h0000000, nib_i};
    for (int i = 0; i < 4; i++) begin
      if (crc_v[0]) begin
        crc_v = (crc_v >> 1) ^ CRC_POLY;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/enet_mii_tx.sv
// MII transmitter: pulls bytes from a show-ahead FIFO and emits
// preamble/SFD, payload, optional zero pad, FCS and the inter-frame gap.
// All MII outputs are registered; pop_o is combinational so it consumes
// the byte currently presented by the FIFO.
module enet_mii_tx
  import enet_pkg::*;
#(
  parameter int IFG_CYCLES = 24,
  parameter int PAD_EN     = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       empty_i,
  output logic       pop_o,
  output logic [3:0] mii_txd_o,
  output logic       mii_txen_o,
  output logic       mii_txer_o,
  output logic       frame_done_o,
  output logic       underrun_o
);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic        hi_q, hi_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        txer_q, txer_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;

  logic        pop_s;
  logic [3:0]  crc_nib_s;
  logic [31:0] crc_next_s;
  logic [31:0] crc_inv_s;
  logic [5:0]  bc_inc_s;

  enet_crc32_nibble u_crc (
    .crc_i (crc_q),
    .nib_i (crc_nib_s),
    .crc_o (crc_next_s)
  );

  assign crc_inv_s = ~crc_q;
  assign bc_inc_s  = byte_cnt_inc(byte_cnt_q);

  // Next-state, counters, CRC and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    crc_d      = crc_q;
    crc_nib_s  = 4'h0;
    txd_d      = 4'h0;
    txen_d     = 1'b0;
    txer_d     = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    pop_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The first preamble nibble leaves on the decision cycle so the
        // gap after IFG is exactly IFG_CYCLES long on the wire.
        if (!empty_i) begin
          state_d    = ST_PREAMBLE;
          cnt_d      = 16'd1;
          byte_cnt_d = 6'd0;
          hi_d       = 1'b0;
          crc_d      = CRC_INIT;
          txd_d      = NIB_PREAMBLE;
          txen_d     = 1'b1;
        end else begin
          cnt_d = 16'd0;
        end
      end

      ST_PREAMBLE: begin
        txen_d = 1'b1;
        if (cnt_q == 16'd15) begin
          txd_d   = NIB_SFD;
          state_d = ST_DATA;
          cnt_d   = 16'd0;
        end else begin
          txd_d = NIB_PREAMBLE;
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (empty_i) begin
          // FIFO ran dry: flag the error on the wire, then drain the rest.
          txen_d     = 1'b1;
          txer_d     = 1'b1;
          underrun_d = 1'b1;
          hi_d       = 1'b0;
          state_d    = ST_DISCARD;
        end else if (!hi_q) begin
          txen_d    = 1'b1;
          txd_d     = data_i[3:0];
          crc_nib_s = data_i[3:0];
          crc_d     = crc_next_s;
          hi_d      = 1'b1;
        end else begin
          txen_d     = 1'b1;
          txd_d      = data_i[7:4];
          crc_nib_s  = data_i[7:4];
          crc_d      = crc_next_s;
          hi_d       = 1'b0;
          pop_s      = 1'b1;
          byte_cnt_d = bc_inc_s;
          if (last_i) begin
            if ((PAD_EN != 0) && (bc_inc_s < MIN_FRAME)) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
              cnt_d   = 16'd0;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_PAD: begin
        txen_d    = 1'b1;
        txd_d     = 4'h0;
        crc_nib_s = 4'h0;
        crc_d     = crc_next_s;
        if (!hi_q) begin
          hi_d = 1'b1;
        end else begin
          hi_d       = 1'b0;
          byte_cnt_d = bc_inc_s;
          if (bc_inc_s == MIN_FRAME) begin
            state_d = ST_FCS;
            cnt_d   = 16'd0;
          end else begin
            state_d = ST_PAD;
          end
        end
      end

      ST_FCS: begin
        txen_d = 1'b1;
        txd_d  = crc_inv_s[{cnt_q[2:0], 2'b00} +: 4];
        if (cnt_q == 16'd7) begin
          done_d  = 1'b1;
          state_d = ST_IFG;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_IFG: begin
        if (cnt_q == 16'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DISCARD: begin
        if (!empty_i) begin
          pop_s = 1'b1;
          if (last_i) begin
            state_d = ST_IFG;
            cnt_d   = 16'd0;
          end else begin
            state_d = ST_DISCARD;
          end
        end else begin
          state_d = ST_DISCARD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State, counters, CRC and MII output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      byte_cnt_q <= 6'd0;
      hi_q       <= 1'b0;
      crc_q      <= CRC_INIT;
      txd_q      <= 4'h0;
      txen_q     <= 1'b0;
      txer_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      txer_q     <= txer_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  // Pop is gated by reset so nothing is consumed while the FIFO is cleared.
  assign pop_o        = pop_s & rst_i;
  assign mii_txd_o    = txd_q;
  assign mii_txen_o   = txen_q;
  assign mii_txer_o   = txer_q;
  assign frame_done_o = done_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_enet_mii_tx.sv
// Directed bench for enet_mii_tx with a queue-based show-ahead FIFO model
// and a wire monitor that captures every txen-high burst.
module tb_enet_mii_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       last_i;
  logic       empty_i;
  logic       pop_o;
  logic [3:0] mii_txd_o;
  logic       mii_txen_o;
  logic       mii_txer_o;
  logic       frame_done_o;
  logic       underrun_o;

  enet_mii_tx #(.IFG_CYCLES(24), .PAD_EN(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .empty_i      (empty_i),
    .pop_o        (pop_o),
    .mii_txd_o    (mii_txd_o),
    .mii_txen_o   (mii_txen_o),
    .mii_txer_o   (mii_txer_o),
    .frame_done_o (frame_done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [8:0] fifo_q[$];
  logic       pop_seen = 1'b0;

  task automatic fifo_refresh();
    if (fifo_q.size() == 0) begin
      empty_i = 1'b1;
      data_i  = 8'h00;
      last_i  = 1'b0;
    end else begin
      empty_i = 1'b0;
      data_i  = fifo_q[0][7:0];
      last_i  = fifo_q[0][8];
    end
  endtask

  task automatic fifo_push(input logic [7:0] d, input logic l);
    fifo_q.push_back({l, d});
    fifo_refresh();
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // ---------------- wire monitor ----------------
  logic [3:0] cur_q[$];
  logic [3:0] last_frame[$];
  logic       in_frame = 1'b0;
  logic       prev_txer = 1'b0;
  int frames_seen = 0, gap_cnt = 0, last_gap = 0;
  int done_cnt = 0, underrun_cnt = 0, txer_cnt = 0, txer_txen = 0, txer_then_low = 0;
  int pop_viol = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      pop_seen = pop_o;
      if (pop_o && empty_i) pop_viol++;
      if (mii_txen_o) begin
        if (!in_frame) begin
          last_gap = gap_cnt;
          in_frame = 1'b1;
          cur_q.delete();
        end
        cur_q.push_back(mii_txd_o);
        gap_cnt = 0;
      end else begin
        if (in_frame) begin
          in_frame    = 1'b0;
          last_frame  = cur_q;
          frames_seen++;
        end
        gap_cnt++;
      end
      if (mii_txer_o) begin
        txer_cnt++;
        if (mii_txen_o) txer_txen++;
      end
      if (prev_txer && !mii_txen_o) txer_then_low++;
      prev_txer = mii_txer_o;
      if (frame_done_o) done_cnt++;
      if (underrun_o) underrun_cnt++;
    end
  end

  // Bit-serial reflected CRC-32 over the captured frame after the SFD.
  function automatic logic [31:0] frame_residue();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 16; i < last_frame.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        fb = c[0] ^ last_frame[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  function automatic int preamble_errs();
    int bad;
    bad = 0;
    for (int i = 0; i < 15; i++) if (last_frame[i] !== 4'h5) bad++;
    if (last_frame[15] !== 4'hD) bad++;
    return bad;
  endfunction

  task automatic wait_frames(input int n, input string tag);
    int k;
    k = 0;
    while (frames_seen < n && k < 800) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check_eq(tag, (frames_seen >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic push_at_edge();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    int bad;
    int k;
    int d0, u0, t0, tl0, tt0;
    logic [7:0] b;

    rst_i = 1'b0;
    fifo_refresh();
    idle_cycles(5);

    // Reset state
    check_eq("rst_txen", 32'(mii_txen_o), 32'd0);
    check_eq("rst_txd", 32'(mii_txd_o), 32'd0);
    check_eq("rst_txer", 32'(mii_txer_o), 32'd0);
    check_eq("rst_pop", 32'(pop_o), 32'd0);
    check_eq("rst_done", 32'(frame_done_o), 32'd0);
    check_eq("rst_underrun", 32'(underrun_o), 32'd0);
    rst_i = 1'b1;
    idle_cycles(3);

    // Single byte 0xAB, padded to 60 bytes
    d0 = done_cnt;
    push_at_edge();
    fifo_push(8'hAB, 1'b1);
    wait_frames(1, "f1_wait");
    check_eq("f1_len", 32'(last_frame.size()), 32'd144);
    check_eq("f1_preamble", 32'(preamble_errs()), 32'd0);
    check_eq("f1_nib_lo", 32'(last_frame[16]), 32'hB);
    check_eq("f1_nib_hi", 32'(last_frame[17]), 32'hA);
    bad = 0;
    for (int i = 18; i < 136; i++) if (last_frame[i] !== 4'h0) bad++;
    check_eq("f1_pad_zero", 32'(bad), 32'd0);
    check_eq("f1_residue", frame_residue(), 32'hDEBB20E3);
    idle_cycles(2);
    check_eq("f1_done_once", 32'(done_cnt - d0), 32'd1);
    idle_cycles(30);

    // 64-byte frame 0x00..0x3F, no pad
    push_at_edge();
    for (int i = 0; i < 64; i++) fifo_push(8'(i), (i == 63) ? 1'b1 : 1'b0);
    wait_frames(2, "f2_wait");
    check_eq("f2_len", 32'(last_frame.size()), 32'd152);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      if (last_frame[16 + 2 * i] !== b[3:0]) bad++;
      if (last_frame[17 + 2 * i] !== b[7:4]) bad++;
    end
    check_eq("f2_payload", 32'(bad), 32'd0);
    check_eq("f2_residue", frame_residue(), 32'hDEBB20E3);
    idle_cycles(30);

    // Two 60-byte frames back-to-back
    push_at_edge();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 60; i++) fifo_push(8'(8'hC0 + i + f), (i == 59) ? 1'b1 : 1'b0);
    wait_frames(3, "f3a_wait");
    check_eq("f3a_len", 32'(last_frame.size()), 32'd144);
    check_eq("f3a_residue", frame_residue(), 32'hDEBB20E3);
    wait_frames(4, "f3b_wait");
    check_eq("f3_gap", 32'(last_gap), 32'd24);
    check_eq("f3b_len", 32'(last_frame.size()), 32'd144);
    check_eq("f3b_residue", frame_residue(), 32'hDEBB20E3);
    check_eq("no_txer_yet", 32'(txer_cnt), 32'd0);
    idle_cycles(30);

    // Underrun after byte 10 of a 20-byte frame
    d0 = done_cnt; u0 = underrun_cnt; t0 = txer_cnt; tt0 = txer_txen; tl0 = txer_then_low;
    push_at_edge();
    for (int i = 0; i < 10; i++) fifo_push(8'(8'h10 + i), 1'b0);
    k = 0;
    while (underrun_cnt == u0 && k < 200) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check_eq("ur_pulse", 32'(underrun_cnt - u0), 32'd1);
    idle_cycles(1);
    check_eq("ur_txer_once", 32'(txer_cnt - t0), 32'd1);
    check_eq("ur_txer_txen", 32'(txer_txen - tt0), 32'd1);
    check_eq("ur_then_low", 32'(txer_then_low - tl0), 32'd1);
    check_eq("ur_len", 32'(last_frame.size()), 32'd37);
    push_at_edge();
    for (int i = 10; i < 20; i++) fifo_push(8'(8'h10 + i), (i == 19) ? 1'b1 : 1'b0);
    idle_cycles(30);
    check_eq("ur_drained", 32'(fifo_q.size()), 32'd0);
    check_eq("ur_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("ur_no_txen", 32'(frames_seen), 32'd5);
    push_at_edge();
    fifo_push(8'h5A, 1'b1);
    wait_frames(6, "ur_next_wait");
    check_eq("ur_next_len", 32'(last_frame.size()), 32'd144);
    check_eq("ur_next_lo", 32'(last_frame[16]), 32'hA);
    check_eq("ur_next_residue", frame_residue(), 32'hDEBB20E3);
    idle_cycles(30);

    // Reset during FCS nibble 3
    d0 = done_cnt;
    push_at_edge();
    fifo_push(8'h77, 1'b1);
    k = 0;
    while (!(in_frame && cur_q.size() == 139) && k < 400) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check_eq("rf_reach_fcs3", (k < 400) ? 32'd1 : 32'd0, 32'd1);
    rst_i = 1'b0;
    idle_cycles(1);
    check_eq("rf_txen", 32'(mii_txen_o), 32'd0);
    check_eq("rf_txd", 32'(mii_txd_o), 32'd0);
    check_eq("rf_txer", 32'(mii_txer_o), 32'd0);
    check_eq("rf_pop", 32'(pop_o), 32'd0);
    check_eq("rf_done", 32'(frame_done_o), 32'd0);
    check_eq("rf_underrun", 32'(underrun_o), 32'd0);
    fifo_q.delete();
    fifo_refresh();
    idle_cycles(2);
    rst_i = 1'b1;
    idle_cycles(4);
    check_eq("rf_idle_txen", 32'(mii_txen_o), 32'd0);
    check_eq("rf_trunc_len", 32'(last_frame.size()), 32'd139);
    check_eq("rf_no_done", 32'(done_cnt - d0), 32'd0);
    push_at_edge();
    fifo_push(8'h12, 1'b0);
    fifo_push(8'h34, 1'b1);
    wait_frames(8, "rf_next_wait");
    check_eq("rf_next_len", 32'(last_frame.size()), 32'd144);
    check_eq("rf_next_preamble", 32'(preamble_errs()), 32'd0);
    check_eq("rf_next_b0", 32'({last_frame[17], last_frame[16]}), 32'h12);
    check_eq("rf_next_b1", 32'({last_frame[19], last_frame[18]}), 32'h34);
    check_eq("rf_next_residue", frame_residue(), 32'hDEBB20E3);
    idle_cycles(5);

    check_eq("pop_while_empty", 32'(pop_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
